// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding, timing constants and expected toggle-count helper shared by
// the PLL lock sequencer and its feedback counter.
package pll_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_ENABLE_WAIT = 3'd2,
    ST_MEASURE     = 3'd3,
    ST_LOCKED      = 3'd4,
    ST_FAIL        = 3'd5
  } state_t;

  localparam int RESET_HOLD_CYC = 4;
  localparam int TOGGLE_DIV     = 16;

  function automatic logic [15:0] exp_count(input logic [4:0] div, input int win);
    return 16'((32'(div) * win) / TOGGLE_DIV);
  endfunction
endpackage

// File: rtl/pll_fb_counter.sv
// pll_fb_counter: synchronizes the PLL feedback toggle, counts edges over fixed reference
// windows and flags each window end with an in-tolerance verdict.
module pll_fb_counter
  import pll_seq_pkg::*;
#(
  parameter int WIN_CYC = 32,
  parameter int TOL     = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       i_en,
  input  logic       i_fb_toggle,
  input  logic [4:0] i_div,
  output logic       o_window_done,
  output logic       o_window_good
);
  localparam int TW = $clog2(WIN_CYC);
  logic          r_s1, r_s2, r_s3;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_count;
  logic          w_edge;
  logic [7:0]    w_fin;
  logic [16:0]   w_exp, w_cnt, w_diff;
  assign w_edge        = r_s2 ^ r_s3;
  // the edge seen in the last window cycle still belongs to that window
  assign w_fin         = (w_edge && r_count != 8'hff) ? r_count + 8'd1 : r_count;
  assign o_window_done = i_en && (r_timer == TW'(WIN_CYC - 1));
  assign w_exp         = {1'b0, exp_count(i_div, WIN_CYC)};
  assign w_cnt         = {9'd0, w_fin};
  assign w_diff        = (w_cnt >= w_exp) ? w_cnt - w_exp : w_exp - w_cnt;
  assign o_window_good = w_diff <= 17'(TOL);
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_timer <= '0;
      r_count <= '0;
    end else begin
      r_s1    <= i_fb_toggle;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_timer <= i_en ? r_timer + TW'(1) : '0;
      r_count <= (!i_en || o_window_done) ? '0 : w_fin;
    end
  end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reference-domain bring-up, frequency-lock verification and retry control for
// the ring-oscillator PLL. Define PLL_LOCK_MONITOR_EN to keep checking windows while locked.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 256,
  parameter int WIN_CYC    = 32,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  cfg_div,
  input  logic        cfg_dco,
  input  logic [25:0] cfg_trim,
  input  logic        fb_toggle,
  output logic        pll_resetb,
  output logic        pll_enable,
  output logic        pll_dco,
  output logic [4:0]  pll_div,
  output logic [25:0] pll_ext_trim,
  output logic        locked,
  output logic        clk_sel,
  output logic        fail,
  output logic [2:0]  state_o
);
  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n, r_win, w_win_n;
  logic [7:0]  r_good, w_good_n, r_retry, w_retry_n;
  logic        r_resetb, w_resetb_n, r_enable, w_enable_n, r_dco, w_dco_n;
  logic        r_locked, w_locked_n, r_clk_sel, w_clk_sel_n, r_fail, w_fail_n;
  logic [4:0]  r_div, w_div_n;
  logic [25:0] r_trim, w_trim_n;
  logic        w_meas_en, w_window_done, w_window_good, w_retry_go;
`ifdef PLL_LOCK_MONITOR_EN
  logic        r_bad, w_bad_n, r_drop, w_drop_n;
  assign w_meas_en = r_state == ST_MEASURE || (r_state == ST_LOCKED && !r_dco);
`else
  assign w_meas_en = r_state == ST_MEASURE;
`endif
  pll_fb_counter #(.WIN_CYC(WIN_CYC), .TOL(TOL)) u_fb (
    .clock         (clock),
    .resetb        (resetb),
    .i_en          (w_meas_en),
    .i_fb_toggle   (fb_toggle),
    .i_div         (r_div),
    .o_window_done (w_window_done),
    .o_window_good (w_window_good)
  );
  assign pll_resetb   = r_resetb;
  assign pll_enable   = r_enable;
  assign pll_dco      = r_dco;
  assign pll_div      = r_div;
  assign pll_ext_trim = r_trim;
  // stop must release the system clock in the very cycle it is asserted
  assign locked       = r_locked & ~stop;
  assign clk_sel      = r_clk_sel & ~stop;
  assign fail         = r_fail;
  assign state_o      = r_state;
  always_comb begin
    w_state_n = r_state; w_cnt_n = r_cnt; w_win_n = r_win; w_good_n = r_good; w_retry_n = r_retry;
    w_resetb_n = r_resetb; w_enable_n = r_enable; w_dco_n = r_dco; w_div_n = r_div; w_trim_n = r_trim;
    w_locked_n = r_locked; w_clk_sel_n = r_clk_sel; w_fail_n = r_fail; w_retry_go = 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
    w_bad_n = (r_state == ST_LOCKED) ? r_bad : 1'b0;
    w_drop_n = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_FAIL: if (start && !stop) begin
        w_dco_n = cfg_dco; w_div_n = cfg_div; w_trim_n = cfg_trim;
        w_retry_n = '0; w_fail_n = 1'b0; w_cnt_n = '0; w_state_n = ST_RESET;
      end
      ST_RESET: if (r_cnt == 16'(RESET_HOLD_CYC - 1)) begin
        w_cnt_n = '0; w_resetb_n = 1'b1; w_enable_n = 1'b1; w_state_n = ST_ENABLE_WAIT;
      end else w_cnt_n = r_cnt + 16'd1;
      ST_ENABLE_WAIT: if (r_cnt == 16'(SETTLE_CYC - 1)) begin
        w_cnt_n = '0; w_good_n = '0; w_win_n = '0;
        w_state_n = r_dco ? ST_LOCKED : ST_MEASURE;
        w_locked_n = r_dco;
      end else w_cnt_n = r_cnt + 16'd1;
      ST_MEASURE: if (w_window_done) begin
        w_good_n = w_window_good ? r_good + 8'd1 : '0;
        w_win_n = r_win + 16'd1;
        if (w_window_good && r_good == 8'(LOCK_CNT - 1)) begin
          w_state_n = ST_LOCKED; w_locked_n = 1'b1; w_cnt_n = '0;
        end else if (r_win == 16'(16 * LOCK_CNT - 1)) w_retry_go = 1'b1;
      end
      ST_LOCKED: begin
        if (!r_clk_sel) begin
          if (r_cnt == 16'd1) w_clk_sel_n = 1'b1;
          else w_cnt_n = r_cnt + 16'd1;
        end
`ifdef PLL_LOCK_MONITOR_EN
        // clk_sel drops first so the system is off the PLL before lock is withdrawn
        if (r_drop) begin
          w_clk_sel_n = 1'b0; w_locked_n = 1'b0; w_retry_go = 1'b1;
        end else if (!r_dco && w_window_done) begin
          w_bad_n = !w_window_good;
          if (!w_window_good && r_bad) begin
            w_clk_sel_n = 1'b0; w_drop_n = 1'b1;
          end
        end
`endif
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_retry_go) begin
      w_cnt_n = '0; w_resetb_n = 1'b0; w_enable_n = 1'b0;
      if (r_retry < 8'(MAX_RETRY)) begin
        w_retry_n = r_retry + 8'd1; w_state_n = ST_RESET;
      end else begin
        w_state_n = ST_FAIL; w_fail_n = 1'b1; w_dco_n = 1'b0; w_div_n = '0; w_trim_n = '0;
        w_locked_n = 1'b0; w_clk_sel_n = 1'b0;
      end
    end
    if (stop) begin
      w_state_n = ST_IDLE; w_cnt_n = '0; w_resetb_n = 1'b0; w_enable_n = 1'b0; w_dco_n = 1'b0;
      w_div_n = '0; w_trim_n = '0; w_locked_n = 1'b0; w_clk_sel_n = 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
      w_drop_n = 1'b0;
`endif
    end
  end
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_IDLE; r_cnt <= '0; r_win <= '0; r_good <= '0; r_retry <= '0;
      r_resetb <= 1'b0; r_enable <= 1'b0; r_dco <= 1'b0; r_div <= '0; r_trim <= '0;
      r_locked <= 1'b0; r_clk_sel <= 1'b0; r_fail <= 1'b0;
    end else begin
      r_state <= w_state_n; r_cnt <= w_cnt_n; r_win <= w_win_n; r_good <= w_good_n; r_retry <= w_retry_n;
      r_resetb <= w_resetb_n; r_enable <= w_enable_n; r_dco <= w_dco_n; r_div <= w_div_n; r_trim <= w_trim_n;
      r_locked <= w_locked_n; r_clk_sel <= w_clk_sel_n; r_fail <= w_fail_n;
    end
  end
`ifdef PLL_LOCK_MONITOR_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_bad  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_bad  <= w_bad_n;
      r_drop <= w_drop_n;
    end
  end
`endif
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed and randomized bring-up scenarios checked against a
// window-count model of the lock rules; a second instance exercises counter saturation.
module tb_pll_lock_sequencer;
  localparam int SETTLE = 256, WIN = 32, TOL = 2, LCNT = 4;
  localparam int LOCK_DLY = SETTLE + LCNT * WIN;
  localparam int TMO_DLY  = SETTLE + 16 * LCNT * WIN;
  logic clk = 0, rstn = 0, start = 0, stop = 0, fb = 0;
  logic [4:0] cfg_div = '0;
  logic cfg_dco = 0;
  logic [25:0] cfg_trim = '0;
  logic pll_resetb, pll_enable, pll_dco, locked, clk_sel, fail;
  logic [4:0] pll_div;
  logic [25:0] pll_ext_trim;
  logic [2:0] state_o;
  logic start2 = 0, fb2 = 0;
  logic s_resetb, s_enable, s_dco, s_locked, s_clk_sel, s_fail;
  logic [4:0] s_div;
  logic [25:0] s_trim;
  logic [2:0] s_state;
  int checks = 0, failures = 0, tgl_n = 0, k = 0;
  int bnd[4] = '{14, 18, 13, 19};

  pll_lock_sequencer dut (
    .clock(clk), .resetb(rstn), .start(start), .stop(stop), .cfg_div(cfg_div), .cfg_dco(cfg_dco),
    .cfg_trim(cfg_trim), .fb_toggle(fb), .pll_resetb(pll_resetb), .pll_enable(pll_enable),
    .pll_dco(pll_dco), .pll_div(pll_div), .pll_ext_trim(pll_ext_trim), .locked(locked),
    .clk_sel(clk_sel), .fail(fail), .state_o(state_o)
  );
  // long window and single-window lock so a toggle every cycle must saturate at 255
  pll_lock_sequencer #(.SETTLE_CYC(4), .WIN_CYC(512), .LOCK_CNT(1)) dut_sat (
    .clock(clk), .resetb(rstn), .start(start2), .stop(1'b0), .cfg_div(5'd8), .cfg_dco(1'b0),
    .cfg_trim(26'd0), .fb_toggle(fb2), .pll_resetb(s_resetb), .pll_enable(s_enable),
    .pll_dco(s_dco), .pll_div(s_div), .pll_ext_trim(s_trim), .locked(s_locked),
    .clk_sel(s_clk_sel), .fail(s_fail), .state_o(s_state)
  );

  always #5 clk = ~clk;
  // 32-cycle periodic pattern: any 32-cycle window sees exactly tgl_n toggles
  always @(negedge clk) begin
    k++;
    if ((k % 32) < tgl_n) fb = ~fb;
    fb2 = ~fb2;
  end

  function automatic bit win_good(input int n, input int div);
    int e;
    e = div * WIN / 16;
    return ((n > e) ? n - e : e - n) <= TOL;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [4:0] div, input logic dco, input logic [25:0] trim);
    cfg_div = div; cfg_dco = dco; cfg_trim = trim; start = 1;
    @(negedge clk);
    start = 0; cfg_div = ~div; cfg_dco = ~dco; cfg_trim = ~trim;
  endtask

  task automatic stop_pll();
    stop = 1;
    @(negedge clk);
    stop = 0;
    @(negedge clk);
  endtask

  task automatic observe(output int rst_cyc, output int delta, output logic lock_ev);
    int t;
    t = 0; rst_cyc = 0;
    while (pll_enable !== 1'b1 && t < 100) begin
      if (state_o == 3'd1 && pll_resetb === 1'b0) rst_cyc++;
      @(negedge clk); t++;
    end
    t = 0;
    while (locked !== 1'b1 && pll_enable === 1'b1 && t < 3000) begin
      @(negedge clk); t++;
    end
    delta = t; lock_ev = locked;
  endtask

  initial begin
    int rc, d, n, t;
    logic le;
    logic [4:0] dv;
    bit g;
    #1;
    check("rst_ctl", {pll_resetb, pll_enable, pll_dco, pll_div}, 0);
    check("rst_trim", pll_ext_trim, 0);
    check("rst_status", {locked, clk_sel, fail, state_o}, 0);
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    tgl_n = 16; go(5'd8, 1'b0, 26'h0);
    observe(rc, d, le);
    check("t1_reset_len", rc, 4);
    check("t1_locked", le, 1);
    check("t1_lock_delay", d, LOCK_DLY);
    check("t1_clksel_l0", clk_sel, 0);
    @(negedge clk); check("t1_clksel_l1", clk_sel, 0);
    @(negedge clk); check("t1_clksel_l2", clk_sel, 1);
    check("t1_div_kept", pll_div, 8);
    check("t1_dco", pll_dco, 0);
    go(5'd3, 1'b1, 26'h3);
    repeat (100) @(negedge clk);
    check("t1_start_ignored", state_o, 4);
    check("t1_div_after_start", pll_div, 8);
    cfg_div = 5'd5; start = 1; stop = 1;
    #1;
    check("stop_locked_now", locked, 0);
    check("stop_clksel_now", clk_sel, 0);
    @(negedge clk);
    start = 0; stop = 0;
    check("stop_state_idle", state_o, 0);
    check("stop_ctl_reset", {pll_resetb, pll_enable, pll_div}, 0);
    @(negedge clk);
    check("stop_no_relatch", state_o, 0);
    go(5'd17, 1'b1, 26'h155_5555);
    observe(rc, d, le);
    check("dco_reset_len", rc, 4);
    check("dco_locked", le, 1);
    check("dco_lock_delay", d, SETTLE);
    check("dco_trim", pll_ext_trim, 26'h1555555);
    check("dco_mode", pll_dco, 1);
    stop_pll();
    foreach (bnd[i]) begin
      tgl_n = bnd[i]; g = win_good(bnd[i], 8);
      go(5'd8, 1'b0, 26'h0);
      observe(rc, d, le);
      check($sformatf("bnd%0d_locked", bnd[i]), le, g);
      check($sformatf("bnd%0d_delay", bnd[i]), d, g ? LOCK_DLY : TMO_DLY);
      stop_pll();
    end
    for (int i = 0; i < 6; i++) begin
      dv = 5'($urandom_range(2, 14));
      n = 2 * int'(dv) + int'($urandom_range(0, 8)) - 4;
      g = win_good(n, int'(dv));
      tgl_n = n;
      go(dv, 1'b0, 26'($urandom));
      observe(rc, d, le);
      check($sformatf("rnd%0d_div%0d_n%0d_locked", i, dv, n), le, g);
      check($sformatf("rnd%0d_delay", i), d, g ? LOCK_DLY : TMO_DLY);
      stop_pll();
    end
    tgl_n = 20; go(5'd8, 1'b0, 26'h0);
    for (int a = 0; a < 4; a++) begin
      observe(rc, d, le);
      check($sformatf("fail_try%0d_reset_len", a), rc, 4);
      check($sformatf("fail_try%0d_delay", a), d, TMO_DLY);
    end
    check("fail_state", state_o, 5);
    check("fail_flag", fail, 1);
    check("fail_ctl", {pll_resetb, pll_enable, pll_dco, pll_div, clk_sel, locked}, 0);
    repeat (50) @(negedge clk);
    check("fail_sticky", {fail, state_o}, {1'b1, 3'd5});
    tgl_n = 16; go(5'd8, 1'b0, 26'h0);
    check("fail_start_clear", {fail, state_o}, {1'b0, 3'd1});
    repeat (20) @(negedge clk);
    check("mid_enable", pll_enable, 1);
    rstn = 0;
    #1;
    check("mid_reset", {pll_enable, pll_resetb, pll_div, state_o, fail}, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    t = 0;
    while (s_enable !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (s_locked !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    check("sat_lock_delay", t, 4 + 512);
`ifdef PLL_LOCK_MONITOR_EN
    tgl_n = 16; go(5'd8, 1'b0, 26'h0);
    observe(rc, d, le);
    repeat (3) @(negedge clk);
    check("mon_clksel_up", clk_sel, 1);
    tgl_n = 0; t = 0;
    while (clk_sel === 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("mon_locked_hold", locked, 1);
    @(negedge clk);
    check("mon_locked_drop", locked, 0);
    check("mon_state_reset", state_o, 1);
    stop_pll();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
